// File: rtl/bram_arb.sv
// bram_arb: two-requester round-robin arbiter in front of a simple dual-port BRAM.
// Optional build macro BRAM_ARB_INIT_EN compiles in a power-up sweep that writes
// INIT_VAL to every address before arbitration begins.
module bram_arb #(
   parameter int A_WID = 14,
   parameter int D_WID = 32,
   parameter logic [D_WID-1:0] INIT_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req,
   input  logic [1:0]         we,
   input  logic [2*A_WID-1:0] addr,
   input  logic [2*D_WID-1:0] din,
   output logic [1:0]         gnt,
   output logic               rvalid,
   output logic               rid,
   output logic [D_WID-1:0]   rdata,
   output logic               busy,
   output logic               mem_we,
   output logic               mem_porta_en,
   output logic [A_WID-1:0]   mem_wraddr,
   output logic [D_WID-1:0]   mem_din,
   output logic               mem_portb_en,
   output logic [A_WID-1:0]   mem_rdaddr,
   input  logic [D_WID-1:0]   mem_dout
);
   logic             ptr;
   logic             pick;
   logic             any;
   logic             wr;
   logic             in_init;
   logic [A_WID-1:0] sweep_addr;
   logic [A_WID-1:0] sel_addr;
   logic [D_WID-1:0] sel_din;

`ifdef BRAM_ARB_INIT_EN
   typedef enum logic {INIT, ARB} state_t;
   state_t           state, state_nx;
   logic [A_WID-1:0] cnt;

   // state register and sweep counter; cnt stops at the last address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == INIT && cnt != '1) cnt <= cnt + 1'b1;
      end
   end

   // leave INIT once the final address has been written
   always_comb begin
      state_nx = state;
      if (state == INIT && cnt == '1) state_nx = ARB;
   end

   assign busy       = (state == INIT);
   assign in_init    = busy && !rst;
   assign sweep_addr = cnt;
`else
   assign busy       = 1'b0;
   assign in_init    = 1'b0;
   assign sweep_addr = '0;
`endif

   // winner selection: lone request wins, contention goes to ptr; reset masks everything
   always_comb begin
      pick     = (req == 2'b10) ? 1'b1 : (req == 2'b11) ? ptr : 1'b0;
      any      = (|req) && !busy && !rst;
      gnt      = any ? (pick ? 2'b10 : 2'b01) : 2'b00;
      wr       = pick ? we[1] : we[0];
      sel_addr = pick ? addr[A_WID +: A_WID] : addr[0 +: A_WID];
      sel_din  = pick ? din[D_WID +: D_WID] : din[0 +: D_WID];
   end

   // BRAM port drive: sweep owns port A during INIT, otherwise the granted access
   always_comb begin
      mem_we       = in_init || (any && wr);
      mem_porta_en = in_init || (any && wr);
      mem_wraddr   = in_init ? sweep_addr : sel_addr;
      mem_din      = in_init ? INIT_VAL : sel_din;
      mem_portb_en = any && !wr;
      mem_rdaddr   = sel_addr;
   end

   // priority pointer flips away from the winner; read tag registered to match BRAM latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= 1'b0;
         rvalid <= 1'b0;
         rid    <= 1'b0;
      end else begin
         if (any) ptr <= ~pick;
         rvalid <= any && !wr;
         if (any && !wr) rid <= pick;
      end
   end

   assign rdata = mem_dout;
endmodule

// File: tb/tb_bram_arb.sv
// tb_bram_arb: directed table-driven bench for bram_arb with a behavioural BRAM model.
// Covers the INIT sweep when BRAM_ARB_INIT_EN is defined, plain arbitration otherwise.
module tb_bram_arb;
   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req, we;
   logic [2*AW-1:0] addr;
   logic [2*DW-1:0] din;
   logic [1:0]    gnt;
   logic          rvalid, rid, busy;
   logic [DW-1:0] rdata;
   logic          mem_we, mem_porta_en, mem_portb_en;
   logic [AW-1:0] mem_wraddr, mem_rdaddr;
   logic [DW-1:0] mem_din, mem_dout;

   int total = 0;
   int pass  = 0;
   logic busy_seen = 1'b0;

   bram_arb #(.A_WID(AW), .D_WID(DW), .INIT_VAL(32'hA5)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
      .gnt(gnt), .rvalid(rvalid), .rid(rid), .rdata(rdata), .busy(busy),
      .mem_we(mem_we), .mem_porta_en(mem_porta_en), .mem_wraddr(mem_wraddr),
      .mem_din(mem_din), .mem_portb_en(mem_portb_en), .mem_rdaddr(mem_rdaddr),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [16];
   always @(posedge clk) begin
      if (mem_porta_en && mem_we) ram[mem_wraddr] <= mem_din;
      if (mem_portb_en) mem_dout <= ram[mem_rdaddr];
   end

   always @(negedge clk) if (busy) busy_seen = 1'b1;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [3:0] a0,
                        input logic [3:0] a1, input logic [31:0] d0, input logic [31:0] d1);
      req = r; we = w; addr = {a1, a0}; din = {d1, d0};
   endtask

   task automatic sweep(input string tag);
      int n = 0;
      while (busy && n < 40) begin
         chk($sformatf("%s addr%0d", tag, n), 32'(mem_wraddr), 32'(n[3:0]));
         chk($sformatf("%s din%0d", tag, n), mem_din, 32'hA5);
         chk($sformatf("%s we%0d", tag, n), {31'd0, mem_we & mem_porta_en}, 32'd1);
         chk($sformatf("%s gnt%0d", tag, n), 32'(gnt), 32'd0);
         n++;
         @(negedge clk); #1;
      end
      chk({tag, " length"}, n, 16);
   endtask

   typedef struct {
      logic [1:0]  req, we;
      logic [3:0]  a0, a1;
      logic [31:0] d0, d1;
      logic [1:0]  gnt;
      logic        mwe, mpb;
      logic [3:0]  maddr;
      logic [31:0] mdin;
      logic        rv, rid;
      logic [31:0] rd;
   } vec_t;

   vec_t v [13];

   initial begin
      v[0]  = '{2'b01, 2'b01, 4'd3, 4'd0, 32'h12345678, 32'h0,        2'b01, 1, 0, 4'd3, 32'h12345678, 0, 0, 32'h0};
      v[1]  = '{2'b10, 2'b00, 4'd0, 4'd3, 32'h0,        32'h0,        2'b10, 0, 1, 4'd3, 32'h0,        0, 0, 32'h0};
      v[2]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 0, 0, 4'd0, 32'h0,        1, 1, 32'h12345678};
      v[3]  = '{2'b10, 2'b10, 4'd0, 4'd9, 32'h0,        32'hCAFE0009, 2'b10, 1, 0, 4'd9, 32'hCAFE0009, 0, 0, 32'h0};
      v[4]  = '{2'b10, 2'b00, 4'd0, 4'd9, 32'h0,        32'h0,        2'b10, 0, 1, 4'd9, 32'h0,        0, 0, 32'h0};
      v[5]  = '{2'b11, 2'b00, 4'd3, 4'd9, 32'h0,        32'h0,        2'b01, 0, 1, 4'd3, 32'h0,        1, 1, 32'hCAFE0009};
      v[6]  = '{2'b11, 2'b00, 4'd3, 4'd9, 32'h0,        32'h0,        2'b10, 0, 1, 4'd9, 32'h0,        1, 0, 32'h12345678};
      v[7]  = '{2'b11, 2'b00, 4'd3, 4'd9, 32'h0,        32'h0,        2'b01, 0, 1, 4'd3, 32'h0,        1, 1, 32'hCAFE0009};
      v[8]  = '{2'b11, 2'b00, 4'd3, 4'd9, 32'h0,        32'h0,        2'b10, 0, 1, 4'd9, 32'h0,        1, 0, 32'h12345678};
      v[9]  = '{2'b10, 2'b00, 4'd3, 4'd9, 32'h0,        32'h0,        2'b10, 0, 1, 4'd9, 32'h0,        1, 1, 32'hCAFE0009};
      v[10] = '{2'b10, 2'b00, 4'd3, 4'd9, 32'h0,        32'h0,        2'b10, 0, 1, 4'd9, 32'h0,        1, 1, 32'hCAFE0009};
      v[11] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 0, 0, 4'd0, 32'h0,        1, 1, 32'hCAFE0009};
      v[12] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        2'b00, 0, 0, 4'd0, 32'h0,        0, 0, 32'h0};

      rst = 1'b1;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      #1;
      chk("rst gnt", 32'(gnt), 0);
      chk("rst rvalid", {31'd0, rvalid}, 0);
      chk("rst rid", {31'd0, rid}, 0);
      chk("rst mem_we", {31'd0, mem_we}, 0);
      chk("rst porta", {31'd0, mem_porta_en}, 0);
      chk("rst portb", {31'd0, mem_portb_en}, 0);
      repeat (2) @(negedge clk);
`ifdef BRAM_ARB_INIT_EN
      chk("rst busy", {31'd0, busy}, 1);
      drive(2'b11, 2'b00, 4'd7, 4'd2, 0, 0);
      rst = 1'b0;
      #1;
      sweep("sweep1");
      chk("pending gnt", 32'(gnt), 32'b01);
      chk("pending portb", {31'd0, mem_portb_en}, 1);
      chk("pending rdaddr", 32'(mem_rdaddr), 7);
      @(negedge clk);
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      #1;
      chk("init rd rvalid", {31'd0, rvalid}, 1);
      chk("init rd rid", {31'd0, rid}, 0);
      chk("init rd data", rdata, 32'hA5);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      begin
         int n = 0;
         while (mem_wraddr != 4'd9 && n < 40) begin
            @(negedge clk); #1;
            n++;
         end
         chk("reach addr9", 32'(mem_wraddr), 9);
      end
      rst = 1'b1;
      #1;
      chk("mid rst mem_we", {31'd0, mem_we}, 0);
      chk("mid rst porta", {31'd0, mem_porta_en}, 0);
      chk("mid rst busy", {31'd0, busy}, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      sweep("sweep2");
`else
      drive(2'b01, 2'b00, 4'd4, 0, 0, 0);
      #1;
      chk("rst held gnt", 32'(gnt), 0);
      chk("rst held portb", {31'd0, mem_portb_en}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("first cycle gnt", 32'(gnt), 32'b01);
      chk("first cycle portb", {31'd0, mem_portb_en}, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst gnt", 32'(gnt), 0);
      chk("async rst portb", {31'd0, mem_portb_en}, 0);
      @(negedge clk);
      #1;
      chk("dropped rvalid", {31'd0, rvalid}, 0);
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
`endif
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(v[i].req, v[i].we, v[i].a0, v[i].a1, v[i].d0, v[i].d1);
         #1;
         chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(v[i].gnt));
         chk($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, v[i].mwe});
         chk($sformatf("v%0d porta", i), {31'd0, mem_porta_en}, {31'd0, v[i].mwe});
         chk($sformatf("v%0d portb", i), {31'd0, mem_portb_en}, {31'd0, v[i].mpb});
         if (v[i].mwe) begin
            chk($sformatf("v%0d wraddr", i), 32'(mem_wraddr), 32'(v[i].maddr));
            chk($sformatf("v%0d din", i), mem_din, v[i].mdin);
         end
         if (v[i].mpb) chk($sformatf("v%0d rdaddr", i), 32'(mem_rdaddr), 32'(v[i].maddr));
         chk($sformatf("v%0d rvalid", i), {31'd0, rvalid}, {31'd0, v[i].rv});
         if (v[i].rv) begin
            chk($sformatf("v%0d rid", i), {31'd0, rid}, {31'd0, v[i].rid});
            chk($sformatf("v%0d rdata", i), rdata, v[i].rd);
         end
      end
`ifndef BRAM_ARB_INIT_EN
      chk("busy never set", {31'd0, busy_seen}, 0);
`endif
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
